// File: rtl/ej4_pkg.sv
// rtl/ej4_pkg.sv - shared state encoding and default width for the Gray sweep checker
package ej4_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/gray4_decoder.sv
// rtl/gray4_decoder.sv - combinational W-bit Gray to binary decoder
module gray4_decoder #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/gray4_sweep_checker.sv
// rtl/gray4_sweep_checker.sv - sweeps all codes through an external Gray encoder and counts mismatches
// Optional raw-response capture log enabled by defining SWEEP_LOG_EN.
module gray4_sweep_checker
    import ej4_pkg::*;
#(
    parameter int W             = CODE_W,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] dut_a,
    input  logic [W-1:0] dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W:0]   err_count,
    output logic         first_err_valid,
    output logic [W-1:0] first_err_code,
    input  logic [W-1:0] log_addr,
    output logic [W-1:0] log_data
);

    localparam int            CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [W-1:0]  LAST_CODE   = {W{1'b1}};
    localparam logic [W:0]    ERR_MAX     = {1'b1, {W{1'b0}}};

    state_t        r_state;
    logic [W-1:0]  r_code;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_err_count;
    logic          r_first_valid;
    logic [W-1:0]  r_first_code;

    logic [W-1:0]  w_dec;
    logic          w_accept;
    logic          w_mismatch;

    gray4_decoder #(.W(W)) u_dec (
        .i_gray (dut_out),
        .o_bin  (w_dec)
    );

    assign w_accept   = start && (r_state == IDLE || r_state == DONE);
    assign w_mismatch = (w_dec != r_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_code        <= '0;
            r_cnt         <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_code  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state       <= APPLY;
                        r_code        <= '0;
                        r_err_count   <= '0;
                        r_first_valid <= 1'b0;
                        r_first_code  <= '0;
                    end
                end
                APPLY: begin
                    r_state <= SETTLE;
                    r_cnt   <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (r_cnt == '0) r_state <= SAMPLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err_count != ERR_MAX) r_err_count <= r_err_count + 1'b1;
                        if (!r_first_valid) begin
                            r_first_valid <= 1'b1;
                            r_first_code  <= r_code;
                        end
                    end
                    // The final code ends the sweep instead of wrapping back to 0.
                    if (r_code == LAST_CODE) begin
                        r_state <= DONE;
                    end else begin
                        r_code  <= r_code + 1'b1;
                        r_state <= APPLY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dut_a           = r_code;
    assign busy            = (r_state == APPLY) || (r_state == SETTLE) || (r_state == SAMPLE);
    assign done            = (r_state == DONE);
    assign pass            = done && (r_err_count == '0);
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_code  = r_first_code;

`ifdef SWEEP_LOG_EN
    logic [W-1:0] r_log [2**W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**W; i++) r_log[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 2**W; i++) r_log[i] <= '0;
        end else if (r_state == SAMPLE) begin
            r_log[r_code] <= dut_out;
        end
    end

    assign log_data = r_log[log_addr];
`else
    logic w_unused_log_addr;

    assign w_unused_log_addr = ^log_addr;
    assign log_data          = '0;
`endif

endmodule

// File: tb/tb_gray4_sweep_checker.sv
// tb/tb_gray4_sweep_checker.sv - self-checking bench for gray4_sweep_checker with encoder model
module tb_gray4_sweep_checker;

    localparam int W     = 4;
    localparam int N     = 16;
    localparam int SWEEP = 96;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dut_a;
    logic [W-1:0] dut_out;
    logic         busy, done, pass;
    logic [W:0]   err_count;
    logic         first_err_valid;
    logic [W-1:0] first_err_code;
    logic [W-1:0] log_addr = '0;
    logic [W-1:0] log_data;

    logic [W-1:0] resp [N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dut_out = resp[dut_a];

    gray4_sweep_checker dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .dut_a           (dut_a),
        .dut_out         (dut_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_code  (first_err_code),
        .log_addr        (log_addr),
        .log_data        (log_data)
    );

    function automatic logic [W-1:0] gray_of(int c);
        return W'(c ^ (c >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_correct();
        for (int c = 0; c < N; c++) resp[c] = gray_of(c);
    endtask

    task automatic load_random_faults(input int rate);
        for (int c = 0; c < N; c++) begin
            resp[c] = gray_of(c);
            if ($urandom_range(0, rate) == 0) resp[c] = resp[c] ^ W'($urandom_range(1, N - 1));
        end
    endtask

    // Expected result: a code fails exactly when the encoder's answer differs from its true Gray code.
    task automatic check_result(input string tag);
        int exp_err = 0;
        int exp_first = 0;
        bit exp_valid = 0;
        for (int c = 0; c < N; c++) begin
            if (resp[c] != gray_of(c)) begin
                exp_err++;
                if (!exp_valid) begin
                    exp_valid = 1;
                    exp_first = c;
                end
            end
        end
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        chk({tag, "_first_valid"}, 32'(first_err_valid), 32'(exp_valid));
        chk({tag, "_first_code"}, 32'(first_err_code), 32'(exp_first));
`ifdef SWEEP_LOG_EN
        for (int c = 0; c < N; c++) begin
            log_addr = W'(c);
            #1;
            chk({tag, "_log"}, 32'(log_data), 32'(resp[c]));
        end
`else
        log_addr = W'($urandom_range(0, N - 1));
        #1;
        chk({tag, "_log_zero"}, 32'(log_data), 32'd0);
`endif
    endtask

    task automatic run_sweep(input string tag, input int repulse_at, input int abort_at);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
        chk({tag, "_accept_clear"}, {done, first_err_valid, 3'b0, err_count}, 32'd0);
        for (int n = 1; n <= SWEEP; n++) begin
            step();
            if (n == repulse_at + 1) start = 1'b0;
            if (n < SWEEP && n % 6 == 0) chk({tag, "_dut_a"}, 32'(dut_a), 32'(n / 6));
            if (n == SWEEP - 1) chk({tag, "_not_done_early"}, 32'(done), 32'd0);
            if (n == repulse_at) start = 1'b1;
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                chk({tag, "_abort_outputs"},
                    {19'b0, busy, done, pass, first_err_valid, first_err_code, dut_a},
                    32'd0);
                chk({tag, "_abort_err"}, 32'(err_count), 32'd0);
                #1;
                rst = 1'b0;
                return;
            end
        end
        chk({tag, "_done_at_96"}, 32'({done, busy}), 32'b10);
        check_result(tag);
        repeat (3) step();
        chk({tag, "_done_held"}, 32'(done), 32'd1);
        check_result({tag, "_hold"});
    endtask

    initial begin
        load_correct();
        #2;
        chk("reset_outputs",
            {19'b0, busy, done, pass, first_err_valid, first_err_code, dut_a}, 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);
        chk("reset_log", 32'(log_data), 32'd0);
        step();
        rst = 1'b0;
        step();

        run_sweep("correct", -1, -1);
`ifdef SWEEP_LOG_EN
        log_addr = 4'd5;
        #1;
        chk("log_addr5", 32'(log_data), 32'b0111);
        log_addr = 4'd15;
        #1;
        chk("log_addr15", 32'(log_data), 32'b1000);
`endif

        for (int c = 0; c < N; c++) resp[c] = gray_of(c) & 4'b1110;
        run_sweep("stuck0", -1, -1);

        for (int c = 0; c < N; c++) resp[c] = gray_of(c) ^ 4'b0100;
        run_sweep("all_bad", -1, -1);

        load_correct();
        run_sweep("abort", -1, 40);
        step();
        run_sweep("after_abort", -1, -1);

        run_sweep("repulse", 20, -1);

        for (int t = 0; t < 4; t++) begin
            load_random_faults(3);
            run_sweep("random", int'($urandom_range(1, 90)), -1);
        end

        load_random_faults(0);
        run_sweep("faulty_then", -1, -1);
        load_correct();
        run_sweep("clean_from_done", -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
